// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared FSM states, constants and FIFO entry type for the LCD display port
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_RDY  = 3'd3,
    CLEAR     = 3'd4
  } lcd_port_state_t;

  // Cycles WAIT_BUSY tolerates lcdReady staying high before assuming the driver already finished
  localparam int LCD_BUSY_TIMEOUT = 15;

  // Entry fields are sized for the widest legal configuration (16 channels, 32-bit words);
  // narrower ports zero-pad the upper bits.
  localparam int LCD_CH_W       = 4;
  localparam int LCD_DATA_MAX_W = 32;

  typedef struct packed {
    logic [LCD_CH_W-1:0]       ch;
    logic [LCD_DATA_MAX_W-1:0] data;
  } lcd_entry_t;

endpackage

// File: rtl/lcd_sync_fifo.sv
// rtl/lcd_sync_fifo.sv - single-clock FIFO with flush, occupancy count and head look-ahead
module lcd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A push into a full FIFO is allowed when the head leaves on the same edge.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_display_port.sv
// rtl/lcd_display_port.sv - CPU-to-LCD update port; LCD_PORT_READBACK_EN adds Rd_Addr/O shadow readback
module lcd_display_port
  import lcd_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Write,
  input  logic [AW-1:0]     Addr,
  input  logic [DATA_W-1:0] I,
  input  logic              Clear_req,
  input  logic              lcdReady,
`ifdef LCD_PORT_READBACK_EN
  input  logic [AW-1:0]     Rd_Addr,
  output logic [DATA_W-1:0] O,
`endif
  output logic              lcd_Write,
  output logic [DATA_W-1:0] lcd_D,
  output logic [AW-1:0]     lcd_Ch,
  output logic              lcd_CLEAR,
  output logic              Busy,
  output logic              Full,
  output logic              Overflow
);

  lcd_port_state_t state;
  lcd_port_state_t next_state;

  logic [NUM_CH-1:0][DATA_W-1:0] shadow;
  lcd_entry_t                    push_entry;
  lcd_entry_t                    head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          addr_ok;
  logic                          wr_accept;
  logic                          pop;
  logic                          write_next;
  logic                          clear_next;
  logic [3:0]                    timer;

  assign addr_ok         = (int'(Addr) < NUM_CH);
  assign wr_accept       = Write && addr_ok;
  assign push_entry.ch   = LCD_CH_W'(Addr);
  assign push_entry.data = LCD_DATA_MAX_W'(I);

  assign Full = fifo_full;
  assign Busy = (state != IDLE) || (fifo_count != '0);

  lcd_sync_fifo #(
    .WIDTH ($bits(lcd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .flush     (Clear_req),
    .push      (wr_accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Shadow register file keeps the last word written to each channel, even if the FIFO drops it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow <= '0;
    end else if (wr_accept) begin
      shadow[Addr] <= I;
    end
  end

  // Next-state and strobe decode; Clear_req overrides everything and aborts any pending issue.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    write_next = 1'b0;
    clear_next = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && lcdReady) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        write_next = 1'b1;
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!lcdReady) begin
          next_state = WAIT_RDY;
        end else if (timer == 4'(LCD_BUSY_TIMEOUT - 1)) begin
          next_state = IDLE;
        end
      end
      WAIT_RDY: begin
        if (lcdReady) next_state = IDLE;
      end
      CLEAR: begin
        if (lcdReady) begin
          clear_next = 1'b1;
          next_state = WAIT_BUSY;
        end
      end
      default: next_state = IDLE;
    endcase
    if (Clear_req) begin
      next_state = CLEAR;
      pop        = 1'b0;
      write_next = 1'b0;
      clear_next = 1'b0;
    end
  end

  // State, registered strobes, output word capture on pop, busy-wait timer and sticky overflow.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      timer     <= '0;
      lcd_Write <= 1'b0;
      lcd_CLEAR <= 1'b0;
      lcd_D     <= '0;
      lcd_Ch    <= '0;
      Overflow  <= 1'b0;
    end else begin
      state     <= next_state;
      lcd_Write <= write_next;
      lcd_CLEAR <= clear_next;
      if (pop) begin
        lcd_D  <= head.data[DATA_W-1:0];
        lcd_Ch <= head.ch[AW-1:0];
      end
      if (state == WAIT_BUSY && next_state == WAIT_BUSY) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
      if (wr_accept && !Clear_req && fifo_full && !pop) begin
        Overflow <= 1'b1;
      end
    end
  end

`ifdef LCD_PORT_READBACK_EN
  assign O = (int'(Rd_Addr) < NUM_CH) ? shadow[Rd_Addr] : '0;

  // Entry padding bits above DATA_W/AW are always zero.
  logic unused_bits;
  assign unused_bits = ^head;
`else
  // Shadow registers are write-only here; entry padding bits are always zero.
  logic unused_bits;
  assign unused_bits = ^{head, shadow};
`endif

endmodule
